debug_host_ctrl: RTL and testbench
==================================

// Module: debug_host_ctrl
// PURPOSE
//  Host-side master for the MIPS debug UART protocol; the initiator that drives the target's debug unit.
//  Streams a program image from a byte ROM, issues run or step commands, and collects the register/memory dump bytes the target returns.
//  Assembles returned bytes into 32-bit words for checking.
//  Sits between a byte-level UART (tx_start/tx_done, rx_data/rx_done) and a local program ROM.
//  Used in board self-test and system simulation.
// PARAMETERS
//  PROG_AW     8      program ROM address width; max image 2^PROG_AW bytes
//  DUMP_WORDS  65     words returned per halt/step (PC + 32 regs + 32 mem words)
//  NB_TIMEOUT  24     rx timeout counter width; timeout at 2^NB_TIMEOUT-1 idle cycles
//  CMD_LOAD    8'h01  load-program command byte
//  CMD_RUN     8'h02  run-until-halt command byte
//  CMD_STEP    8'h03  single-step command byte
// PORTS
//  i_clock       in   1           system clock
//  i_reset       in   1           asynchronous, active-low reset
//  i_start       in   1           1-cycle pulse: begin session (ignored while o_busy)
//  i_prog_len    in   PROG_AW+1   image length in bytes, sampled on accepted i_start
//  i_step_count  in   8           0 = run mode; N>0 = N single steps; sampled on i_start
//  o_prog_addr   out  PROG_AW     ROM byte address
//  i_prog_data   in   8           ROM data, valid 1 cycle after o_prog_addr
//  o_tx_data     out  8           byte to UART; held stable until i_tx_done
//  o_tx_start    out  1           1-cycle pulse: UART begins sending o_tx_data
//  i_tx_done     in   1           1-cycle tick: UART finished current byte
//  i_rx_data     in   8           received byte, valid with i_rx_done
//  i_rx_done     in   1           1-cycle tick: byte received
//  o_dump_word   out  32          assembled dump word
//  o_dump_valid  out  1           1-cycle pulse: o_dump_word/o_dump_index valid
//  o_dump_index  out  8           word index 0..DUMP_WORDS-1 within the current dump
//  o_busy        out  1           session in progress
//  o_done        out  1           level: last session completed OK (cleared by next start)
//  o_error       out  1           level: last session timed out (cleared by next start)
//  o_state       out  4           current FSM state encoding, for LEDs/debug
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE (4'd0), all counters 0. Reset mid-session aborts immediately with no partial tx pulse.
//  FSM states: IDLE(0), TX_LOAD(1), TX_LEN_LO(2), TX_LEN_HI(3), FETCH(4), TX_BYTE(5), TX_EXEC(6), RX_DUMP(7), DONE(8), ERROR(9).
//  From IDLE/DONE/ERROR, i_start -> TX_LOAD: o_busy=1, o_done=o_error=0; o_tx_start pulses in the next cycle.
//  TX handshake, every TX_* state:
//   - drive o_tx_data and pulse o_tx_start once on state entry;
//   - wait for i_tx_done, then advance;
//   - never more than one byte outstanding.
//  Byte order: CMD_LOAD, len[7:0], {pad zeros, len[PROG_AW]} (16-bit length, LSB first), then the image bytes.
//  Image fetch: FETCH drives o_prog_addr=k and waits 1 cycle; TX_BYTE sends i_prog_data; k increments.
//   - After byte len-1 -> TX_EXEC.
//   - len==0 -> TX_EXEC directly after TX_LEN_HI.
//  TX_EXEC sends CMD_RUN if the step count is 0, else CMD_STEP; then -> RX_DUMP with byte/word counters cleared.
//  RX_DUMP assembly:
//   - each i_rx_done shifts in a byte, LSB first;
//   - on the cycle after the 4th byte, o_dump_valid pulses with o_dump_index = word counter;
//   - the word counter then increments.
//  After word DUMP_WORDS-1:
//   - run mode -> DONE;
//   - step mode: decrement remaining steps; if >0 -> TX_EXEC (CMD_STEP, o_dump_index restarts at 0), else -> DONE.
//  DONE: o_busy=0, o_done=1. ERROR: o_busy=0, o_error=1.
//  Timeout (RX_DUMP only): counter clears on entry and on every i_rx_done, else increments; reaching all-ones -> ERROR, partial word discarded.
//  i_rx_done outside RX_DUMP: byte ignored. i_tx_done outside TX_* states: ignored.
//  i_start while o_busy: ignored, sampled inputs unchanged.
//  i_prog_len > 2^PROG_AW: clamp to 2^PROG_AW.
// TESTING
//  1. len=3, ROM=AA,BB,CC, step=0, UART model acks each byte 10 cycles after o_tx_start -> tx sequence 01,03,00,AA,BB,CC,02; exactly one o_tx_start per byte.
//  2. After #1, responder sends 260 bytes starting 10,00,00,00 -> word0=0x00000010, 65 o_dump_valid pulses with index 0..64, then o_done=1, o_busy=0, o_state=8.
//  3. step=2, len=0 -> tx 01,00,00,03; 65 words; tx 03; 65 words (index restarts at 0); DONE.
//  4. NB_TIMEOUT=8, responder silent after CMD_RUN -> o_error=1 after 255 idle cycles, o_state=9; a new i_start clears o_error and restarts.
//  5. i_start pulses while busy, stray i_rx_done bytes during load -> no effect on tx sequence or dump output.
//  6. Assert i_reset=0 between o_tx_start and i_tx_done -> all outputs 0, IDLE; next i_start restarts cleanly from CMD_LOAD.

Source files
------------

// File: rtl/debug_host_ctrl.sv
// Host-side master for the MIPS debug UART protocol: streams a program image,
// issues run/step commands and reassembles the returned dump into 32-bit words.
module debug_host_ctrl #(
  parameter int PROG_AW = 8,
  parameter int DUMP_WORDS = 65,
  parameter int NB_TIMEOUT = 24,
  parameter logic [7:0] CMD_LOAD = 8'h01,
  parameter logic [7:0] CMD_RUN = 8'h02,
  parameter logic [7:0] CMD_STEP = 8'h03
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [PROG_AW:0]   i_prog_len,
  input  logic [7:0]         i_step_count,
  output logic [PROG_AW-1:0] o_prog_addr,
  input  logic [7:0]         i_prog_data,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_done,
  output logic [31:0]        o_dump_word,
  output logic               o_dump_valid,
  output logic [7:0]         o_dump_index,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [3:0]         o_state
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_TX_LOAD = 4'd1;
  localparam logic [3:0] S_LEN_LO  = 4'd2;
  localparam logic [3:0] S_LEN_HI  = 4'd3;
  localparam logic [3:0] S_FETCH   = 4'd4;
  localparam logic [3:0] S_TX_BYTE = 4'd5;
  localparam logic [3:0] S_TX_EXEC = 4'd6;
  localparam logic [3:0] S_RX_DUMP = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;
  localparam logic [3:0] S_ERROR   = 4'd9;

  localparam int unsigned MAX_LEN_I = 1 << PROG_AW;
  localparam logic [PROG_AW:0] MAX_LEN = MAX_LEN_I[PROG_AW:0];
  localparam int unsigned LAST_WORD_I = DUMP_WORDS - 1;
  localparam logic [7:0] LAST_WORD = LAST_WORD_I[7:0];

  logic [3:0]            state_reg;
  logic [PROG_AW:0]      len_reg;
  logic [7:0]            steps_reg;
  logic [PROG_AW:0]      addr_reg;
  logic [7:0]            tx_data_reg;
  logic                  tx_start_reg;
  logic [23:0]           shift_reg;
  logic [1:0]            byte_cnt_reg;
  logic [7:0]            word_cnt_reg;
  logic [NB_TIMEOUT-1:0] tmo_reg;
  logic [31:0]           dump_word_reg;
  logic                  dump_valid_reg;
  logic [7:0]            dump_index_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  error_reg;

  logic [15:0]      len_ext;
  logic [PROG_AW:0] addr_inc;
  logic [PROG_AW:0] start_len;
  logic [7:0]       exec_cmd;

  assign len_ext   = 16'(len_reg);
  assign addr_inc  = addr_reg + 1'b1;
  assign start_len = (i_prog_len > MAX_LEN) ? MAX_LEN : i_prog_len;
  assign exec_cmd  = (steps_reg == 8'd0) ? CMD_RUN : CMD_STEP;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg      <= S_IDLE;
      len_reg        <= '0;
      steps_reg      <= '0;
      addr_reg       <= '0;
      tx_data_reg    <= '0;
      tx_start_reg   <= 1'b0;
      shift_reg      <= '0;
      byte_cnt_reg   <= '0;
      word_cnt_reg   <= '0;
      tmo_reg        <= '0;
      dump_word_reg  <= '0;
      dump_valid_reg <= 1'b0;
      dump_index_reg <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      tx_start_reg   <= 1'b0;
      dump_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            len_reg      <= start_len;
            steps_reg    <= i_step_count;
            addr_reg     <= '0;
            busy_reg     <= 1'b1;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            tx_data_reg  <= CMD_LOAD;
            tx_start_reg <= 1'b1;
            state_reg    <= S_TX_LOAD;
          end
        end
        S_TX_LOAD: begin
          if (i_tx_done) begin
            tx_data_reg  <= len_ext[7:0];
            tx_start_reg <= 1'b1;
            state_reg    <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (i_tx_done) begin
            tx_data_reg  <= len_ext[15:8];
            tx_start_reg <= 1'b1;
            state_reg    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (i_tx_done) begin
            if (len_reg == '0) begin
              tx_data_reg  <= exec_cmd;
              tx_start_reg <= 1'b1;
              state_reg    <= S_TX_EXEC;
            end else begin
              state_reg <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          tx_start_reg <= 1'b1;
          state_reg    <= S_TX_BYTE;
        end
        S_TX_BYTE: begin
          if (i_tx_done) begin
            addr_reg <= addr_inc;
            if (addr_inc == len_reg) begin
              tx_data_reg  <= exec_cmd;
              tx_start_reg <= 1'b1;
              state_reg    <= S_TX_EXEC;
            end else begin
              state_reg <= S_FETCH;
            end
          end
        end
        S_TX_EXEC: begin
          if (i_tx_done) begin
            byte_cnt_reg <= '0;
            word_cnt_reg <= '0;
            tmo_reg      <= '0;
            state_reg    <= S_RX_DUMP;
          end
        end
        S_RX_DUMP: begin
          if (i_rx_done) begin
            tmo_reg      <= '0;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              dump_word_reg  <= {i_rx_data, shift_reg};
              dump_valid_reg <= 1'b1;
              dump_index_reg <= word_cnt_reg;
              word_cnt_reg   <= word_cnt_reg + 8'd1;
              if (word_cnt_reg == LAST_WORD) begin
                // Step mode loops back for another step until the count runs out.
                if (steps_reg > 8'd1) begin
                  steps_reg    <= steps_reg - 8'd1;
                  tx_data_reg  <= CMD_STEP;
                  tx_start_reg <= 1'b1;
                  state_reg    <= S_TX_EXEC;
                end else begin
                  if (steps_reg != 8'd0) steps_reg <= 8'd0;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= S_DONE;
                end
              end
            end else begin
              shift_reg <= {i_rx_data, shift_reg[23:8]};
            end
          end else if (tmo_reg == '1) begin
            busy_reg  <= 1'b0;
            error_reg <= 1'b1;
            state_reg <= S_ERROR;
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // ROM output stays stable while the address is held, so it feeds the UART directly.
  assign o_tx_data    = (state_reg == S_TX_BYTE) ? i_prog_data : tx_data_reg;
  assign o_prog_addr  = addr_reg[PROG_AW-1:0];
  assign o_tx_start   = tx_start_reg;
  assign o_dump_word  = dump_word_reg;
  assign o_dump_valid = dump_valid_reg;
  assign o_dump_index = dump_index_reg;
  assign o_busy       = busy_reg;
  assign o_done       = done_reg;
  assign o_error      = error_reg;
  assign o_state      = state_reg;

endmodule

// File: tb/tb_debug_host_ctrl.sv
// Scoreboard bench for debug_host_ctrl: queued tx bytes and dump words are
// checked by monitors as the DUT emits them; a UART model acks each byte.
module tb_debug_host_ctrl;

  logic       clk;
  logic       i_reset;
  logic       i_start;
  logic [8:0] i_prog_len;
  logic [7:0] i_step_count;
  logic [7:0] o_prog_addr;
  logic [7:0] i_prog_data;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       i_tx_done;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic [31:0] o_dump_word;
  logic       o_dump_valid;
  logic [7:0] o_dump_index;
  logic       o_busy;
  logic       o_done;
  logic       o_error;
  logic [3:0] o_state;

  debug_host_ctrl #(.NB_TIMEOUT(8)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start),
    .i_prog_len(i_prog_len), .i_step_count(i_step_count),
    .o_prog_addr(o_prog_addr), .i_prog_data(i_prog_data),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .o_dump_word(o_dump_word), .o_dump_valid(o_dump_valid),
    .o_dump_index(o_dump_index), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_state(o_state)
  );

  int passed = 0;
  int total = 0;
  logic [7:0]  exp_tx[$];
  int          exp_idx[$];
  logic [31:0] exp_word[$];
  logic [7:0]  rom [0:255];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) i_prog_data <= rom[o_prog_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // UART model: ack each byte 10 cycles after o_tx_start; a reset aborts it.
  initial begin
    logic [7:0] b;
    logic abort;
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      i_tx_done = 1'b0;
      if (i_reset && o_tx_start) begin
        b = o_tx_data;
        abort = 1'b0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (!i_reset) begin
            abort = 1'b1;
            break;
          end
        end
        if (!abort) begin
          check("tx_hold", {24'd0, o_tx_data}, {24'd0, b});
          i_tx_done = 1'b1;
        end
      end
    end
  end

  // tx monitor: one popped expectation per o_tx_start pulse.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (o_tx_start) begin
        $display("tx byte %h", o_tx_data);
        if (exp_tx.size() == 0) check("tx_extra", {24'd0, o_tx_data}, 32'hFFFF_FFFF);
        else begin
          e = exp_tx.pop_front();
          check("tx_byte", {24'd0, o_tx_data}, {24'd0, e});
        end
      end
    end
  end

  // dump monitor: compare index and word on each o_dump_valid pulse.
  initial begin
    int ei;
    logic [31:0] ew;
    forever begin
      @(negedge clk);
      if (o_dump_valid) begin
        $display("dump idx %0d word %h", o_dump_index, o_dump_word);
        if (exp_idx.size() == 0) check("dump_extra", o_dump_word, 32'hDEAD_BEEF);
        else begin
          ei = exp_idx.pop_front();
          ew = exp_word.pop_front();
          check("dump_index", {24'd0, o_dump_index}, ei);
          check("dump_word", o_dump_word, ew);
        end
      end
    end
  end

  function automatic logic [31:0] word_val(input int sess, input int w);
    if (sess == 0 && w == 0) return 32'h0000_0010;
    return {8'(sess), 8'(w), 8'(w) ^ 8'h5A, 8'(w) + 8'h30};
  endfunction

  task automatic wait_state(input logic [3:0] s, input int max_cyc, input string name);
    int n = 0;
    while (o_state !== s && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, {28'd0, o_state}, {28'd0, s});
  endtask

  task automatic do_start(input logic [8:0] len, input logic [7:0] steps);
    @(negedge clk);
    i_prog_len = len;
    i_step_count = steps;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("start_flags", {29'd0, o_busy, o_done, o_error}, 32'd4);
    check("start_state", {28'd0, o_state}, 32'd1);
  endtask

  task automatic send_dump(input int sess);
    logic [31:0] word;
    for (int w = 0; w < 65; w++) begin
      word = word_val(sess, w);
      exp_idx.push_back(w);
      exp_word.push_back(word);
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        i_rx_data = word[8*b +: 8];
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    exp_tx.push_back(b);
  endtask

  initial begin
    int n;
    i_reset = 1'b0;
    i_start = 1'b0;
    i_prog_len = '0;
    i_step_count = '0;
    i_rx_data = '0;
    i_rx_done = 1'b0;
    for (int a = 0; a < 256; a++) rom[a] = 8'h00;
    rom[0] = 8'hAA;
    rom[1] = 8'hBB;
    rom[2] = 8'hCC;
    repeat (3) @(negedge clk);
    check("rst_flags", {27'd0, o_tx_start, o_dump_valid, o_busy, o_done, o_error}, 32'd0);
    check("rst_state", {28'd0, o_state}, 32'd0);
    i_reset = 1'b1;
    repeat (2) @(negedge clk);

    // Load 3 bytes, run, full dump.
    push_tx(8'h01); push_tx(8'h03); push_tx(8'h00);
    push_tx(8'hAA); push_tx(8'hBB); push_tx(8'hCC); push_tx(8'h02);
    do_start(9'd3, 8'd0);
    wait_state(4'd7, 400, "t1_reach_rx");
    check("t1_tx_all_sent", exp_tx.size(), 32'd0);
    send_dump(0);
    wait_state(4'd8, 50, "t2_reach_done");
    check("t2_flags", {29'd0, o_busy, o_done, o_error}, 32'd2);
    check("t2_dump_all_seen", exp_idx.size(), 32'd0);

    // Two single steps, empty image.
    push_tx(8'h01); push_tx(8'h00); push_tx(8'h00); push_tx(8'h03); push_tx(8'h03);
    do_start(9'd0, 8'd2);
    wait_state(4'd7, 400, "t3_reach_rx1");
    send_dump(1);
    wait_state(4'd7, 100, "t3_reach_rx2");
    check("t3_tx_all_sent", exp_tx.size(), 32'd0);
    send_dump(1);
    wait_state(4'd8, 50, "t3_reach_done");
    check("t3_flags", {29'd0, o_busy, o_done, o_error}, 32'd2);
    check("t3_dump_all_seen", exp_idx.size(), 32'd0);

    // Silent responder -> timeout.
    push_tx(8'h01); push_tx(8'h00); push_tx(8'h00); push_tx(8'h02);
    do_start(9'd0, 8'd0);
    wait_state(4'd7, 400, "t4_reach_rx");
    n = 0;
    while (o_state == 4'd7 && n < 600) begin
      @(negedge clk);
      n++;
    end
    $display("timeout after %0d cycles", n);
    check("t4_timeout_cycles", {31'd0, (n >= 254 && n <= 258)}, 32'd1);
    check("t4_state", {28'd0, o_state}, 32'd9);
    check("t4_flags", {29'd0, o_busy, o_done, o_error}, 32'd1);

    // Restart from ERROR with disturbances during the load.
    push_tx(8'h01); push_tx(8'h02); push_tx(8'h00);
    push_tx(8'hAA); push_tx(8'hBB); push_tx(8'h02);
    do_start(9'd2, 8'd0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      i_start = (c % 7 == 3);
      i_prog_len = 9'd5;
      i_step_count = 8'd3;
      i_rx_done = (c % 5 == 1);
      i_rx_data = 8'hEE;
    end
    @(negedge clk);
    i_start = 1'b0;
    i_rx_done = 1'b0;
    wait_state(4'd7, 400, "t5_reach_rx");
    check("t5_tx_all_sent", exp_tx.size(), 32'd0);
    send_dump(2);
    wait_state(4'd8, 50, "t5_reach_done");
    check("t5_dump_all_seen", exp_idx.size(), 32'd0);

    // Reset between o_tx_start and i_tx_done.
    push_tx(8'h01);
    do_start(9'd3, 8'd0);
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_rst_flags", {27'd0, o_tx_start, o_dump_valid, o_busy, o_done, o_error}, 32'd0);
    check("t6_rst_state", {28'd0, o_state}, 32'd0);
    check("t6_rst_word", o_dump_word, 32'd0);
    check("t6_rst_txdata", {16'd0, o_tx_data, o_dump_index}, 32'd0);
    exp_tx.delete();
    i_reset = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_tx_after_rst", {31'd0, o_tx_start}, 32'd0);
    push_tx(8'h01); push_tx(8'h01); push_tx(8'h00); push_tx(8'hAA); push_tx(8'h02);
    do_start(9'd1, 8'd0);
    wait_state(4'd7, 400, "t6_reach_rx");
    check("t6_tx_all_sent", exp_tx.size(), 32'd0);
    send_dump(3);
    wait_state(4'd8, 50, "t6_reach_done");
    check("t6_flags", {29'd0, o_busy, o_done, o_error}, 32'd2);
    check("t6_dump_all_seen", exp_idx.size(), 32'd0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
